// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock LSB first, result registered when the last bit is summed.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             OP_SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa_p0, sb_p0, acc_p0;
  logic             carry_p0;
  logic [CW-1:0]    cnt_p0;
  logic             sum_bit, co_bit;
  logic             launch, last_bit;
  logic [WIDTH-1:0] y_nxt;

  full_adder u_fa (
    .a  (sa_p0[0]),
    .b  (sb_p0[0]),
    .ci (carry_p0),
    .s  (sum_bit),
    .co (co_bit)
  );

  assign launch   = START && (state != RUN);
  assign last_bit = (state == RUN) && (cnt_p0 == LAST);
  assign y_nxt    = {sum_bit, acc_p0[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = START ? RUN : IDLE;
      RUN:     state_nxt = (cnt_p0 == LAST) ? FIN : RUN;
      FIN:     state_nxt = START ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == RUN);
    DONE = (state == FIN);
  end

  // Serial datapath: subtraction folds in ~B and a carry-in of 1 at launch.
  always_ff @(posedge CLK) begin
    if (launch) begin
      sa_p0    <= A;
      sb_p0    <= OP_SUB ? ~B : B;
      carry_p0 <= OP_SUB;
      cnt_p0   <= '0;
    end else if (state == RUN) begin
      sa_p0    <= sa_p0 >> 1;
      sb_p0    <= sb_p0 >> 1;
      acc_p0   <= y_nxt;
      carry_p0 <= co_bit;
      cnt_p0   <= cnt_p0 + 1'b1;
    end
  end

  // Result registers: the carry flop still holds carry-in of the MSB on the last bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Y    <= '0;
      CO   <= 1'b0;
      OVF  <= 1'b0;
      ZERO <= 1'b0;
    end else if (last_bit) begin
      Y    <= y_nxt;
      CO   <= co_bit;
      OVF  <= carry_p0 ^ co_bit;
      ZERO <= (y_nxt == '0);
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed corner cases and random operations
// checked against an arithmetic reference model.

module tb_serial_add_sub;

  localparam int W = 32;

  logic         CLK, RST, START, OP_SUB;
  logic [W-1:0] A, B, Y;
  logic         BUSY, DONE, CO, OVF, ZERO;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OP_SUB(OP_SUB),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE),
    .Y(Y), .CO(CO), .OVF(OVF), .ZERO(ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, co, y} from plain modular / signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    longint sr;
    logic [W:0] full;
    logic [W-1:0] y;
    logic co, ovf;
    if (sub) begin
      y  = a - b;
      co = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      full = {1'b0, a} + {1'b0, b};
      y    = full[W-1:0];
      co   = full[W];
      sr   = longint'($signed(a)) + longint'($signed(b));
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {ovf, co, y};
  endfunction

  // One operation from idle; optional ignored START poke or mid-run reset.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input int poke, input int rst_at);
    logic [W+1:0] m;
    logic [W-1:0] prev_y;
    int ndone;
    m      = model(a, b, sub);
    prev_y = Y;
    ndone  = 0;
    A = a; B = b; OP_SUB = sub; START = 1'b1;
    step;
    START = 1'b0;
    A = $urandom; B = $urandom; OP_SUB = ~sub;
    chk({tag, "_busy_launch"}, BUSY, 1);
    chk({tag, "_done_launch"}, DONE, 0);
    for (int i = 1; i <= W + 3; i++) begin
      if (i == poke) begin START = 1'b1; A = 9; B = 9; OP_SUB = 1'b0; end
      if (i == rst_at) RST = 1'b1;
      step;
      START = 1'b0;
      RST   = 1'b0;
      if (DONE) ndone++;
      if (i == rst_at) begin
        chk({tag, "_rst_busy"}, BUSY, 0);
        chk({tag, "_rst_y"}, Y, 0);
      end else if (i < W && (rst_at == 0 || i < rst_at)) begin
        chk({tag, "_busy_run"}, BUSY, 1);
        chk({tag, "_y_hold"}, Y, prev_y);
      end
      if (i == W && rst_at == 0) begin
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_busy_fin"}, BUSY, 0);
        chk({tag, "_y"}, Y, m[W-1:0]);
        chk({tag, "_co"}, CO, m[W]);
        chk({tag, "_ovf"}, OVF, m[W+1]);
        chk({tag, "_zero"}, ZERO, (m[W-1:0] == '0));
      end
    end
    chk({tag, "_ndone"}, ndone, (rst_at == 0) ? 1 : 0);
  endtask

  initial begin
    int ndone, d1, d2;
    RST = 1'b1; START = 1'b0; OP_SUB = 1'b0; A = '0; B = '0;
    step;
    step;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_y", Y, 0);
    chk("rst_co", CO, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_zero", ZERO, 0);
    RST = 1'b0;
    step;

    run_op("add5p3", 32'd5, 32'd3, 1'b0, 0, 0);
    chk("add5p3_y_const", Y, 32'd8);
    chk("add5p3_co_const", CO, 0);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0);
    chk("add_wrap_zero_const", ZERO, 1);
    chk("add_wrap_co_const", CO, 1);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 0, 0);
    chk("add_ovf_const", OVF, 1);
    run_op("sub7m5", 32'd7, 32'd5, 1'b1, 0, 0);
    chk("sub7m5_y_const", Y, 32'd2);
    run_op("sub5m7", 32'd5, 32'd7, 1'b1, 0, 0);
    chk("sub5m7_y_const", Y, 32'hFFFF_FFFE);
    chk("sub5m7_co_const", CO, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 0, 0);
    chk("sub_ovf_y_const", Y, 32'h7FFF_FFFF);
    run_op("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b1, 0, 0);
    chk("sub_eq_zero_const", ZERO, 1);

    run_op("busy_poke", 32'd1, 32'd1, 1'b0, 10, 0);
    chk("busy_poke_y_const", Y, 32'd2);

    run_op("rst_mid", 32'h1234, 32'h1, 1'b0, 0, 10);
    chk("rst_mid_busy_after", BUSY, 0);
    run_op("after_rst", 32'd2, 32'd2, 1'b0, 0, 0);
    chk("after_rst_y_const", Y, 32'd4);

    for (int r = 0; r < 20; r++)
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 0, 0);

    // START held high: second op accepted in the FIN cycle.
    A = 1; B = 2; OP_SUB = 1'b0; START = 1'b1;
    step;
    A = 3; B = 4;
    ndone = 0; d1 = -1; d2 = -1;
    for (int i = 1; i <= 2 * W + 4; i++) begin
      step;
      if (DONE) begin
        ndone++;
        if (d1 < 0) begin
          d1 = i;
          chk("b2b_y1", Y, 32'd3);
        end else begin
          d2 = i;
          chk("b2b_y2", Y, 32'd7);
        end
      end
    end
    START = 1'b0;
    chk("b2b_ndone", ndone, 2);
    chk("b2b_first_at", d1, W);
    chk("b2b_period", d2 - d1, W + 1);
    for (int i = 0; i < 2 * W && (BUSY || DONE); i++) step;
    chk("b2b_drained", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
